lim_cnt_chain: RTL
==================

# lim_cnt_chain

Parametrised cascade of limited (modulo-L) counter digits with up/down counting, synchronous load and a whole-chain wrap pulse. It generalises the single-digit limited incrementor into a registered N-digit counter with an individual limit per digit. Typical use: mm:ss stopwatch and timer digits feeding the seven-segment display path on the BASYS3 board.

## Interface
- N_DIGITS, 4, number of cascaded digits; digit 0 is least significant.
- W, 4, width of each digit in bits.
- LIMITS, {4'd5,4'd9,4'd5,4'd9}, packed N_DIGITS*W limits; digit i's limit is LIMITS[i*W +: W]; each limit >= 1.
- clk  input  1  rising-edge clock, the only clock.
- reset_n  input  1  synchronous, active-low reset.
- clr  input  1  synchronous clear of all digits to 0.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  N_DIGITS*W  value to load; same packing as count.
- en  input  1  count tick; one step per cycle while high.
- dir  input  1  0 = count up, 1 = count down; sampled with en.
- count  output  N_DIGITS*W  registered digit values; digit i at [i*W +: W].
- co  output  1  registered pulse, high for one cycle when the whole chain wraps.
- load_err  output  1  registered pulse, high for one cycle when a loaded digit exceeded its limit.

## Operation
- Priority at each rising edge: reset_n low > clr > load > en. Lower-priority inputs are ignored in that cycle.
- Reset (reset_n = 0 at an edge): count = 0, co = 0, load_err = 0.
- clr: count = 0, co = 0, load_err = 0.
- load: each digit i takes min(load_val digit i, limit i). load_err = 1 if any digit was clamped, else 0. co = 0.
- en with dir = 0 (up):
  - Digit 0 always steps. Digit i > 0 steps only when every lower digit equals its limit.
  - A stepping digit below its limit increments by 1. A stepping digit at its limit wraps to 0.
- en with dir = 1 (down):
  - Digit 0 always steps. Digit i > 0 steps only when every lower digit equals 0.
  - A stepping digit above 0 decrements by 1. A stepping digit at 0 wraps to its limit.
- co = 1 for the edge where all digits wrap together: up from all-at-limit to all-zero, or down from all-zero to all-at-limit. Otherwise co = 0.
- en low, no clr or load: count holds; co = 0 and load_err = 0 on the next edge.
- A count value with a digit above its limit can only arise through a load, and load clamps it, so this state never exists.
- Arithmetic is per digit in W bits. No digit ever takes a value above its limit.

## Timing
- Latency is 1 cycle for every operation: count, co and load_err update on the same edge that samples the inputs.
- co and load_err are single-cycle pulses and are never held.
- Back-to-back en for K cycles advances count by exactly K steps modulo the chain range.
- Changing dir between consecutive en cycles takes effect immediately; no idle cycle is required.
- load with en high in the same cycle: load wins and no step occurs.
- Reset asserted mid-count: count reads 0 the cycle after; en is ignored during reset.
- All outputs are driven from flip-flops. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset_n = 0 with en = 1 for 3 cycles -> count = 0x0000, co = 0, load_err = 0; release reset_n -> first en edge gives count = 0x0001.
- Up cascade (defaults): load 0x0559, then en = 1 with dir = 0 for one cycle -> count = 0x0600, co = 0. Load 0x5959, one en -> count = 0x0000 and co = 1 for exactly one cycle.
- Down cascade: load 0x1000, one en with dir = 1 -> count = 0x0959. From 0x0000, one down step -> count = 0x5959 with co = 1.
- Load clamp: load_val = 0xF7AF -> count = 0x5759, load_err = 1 for one cycle. Then load 0x1234 -> load_err = 0.
- Priority: clr = load = en = 1 in the same cycle -> count = 0x0000. load = en = 1 with load_val = 0x0102 -> count = 0x0102, with no increment applied.
- Exhaustive sweep: 3600 consecutive up steps from 0 -> count returns to 0x0000 with exactly one co pulse. Every intermediate value matches a reference model in which each digit stays within its limit.

Source files
------------

// File: rtl/lim_cnt_chain.sv
// lim_cnt_chain: cascaded modulo-limit up/down counter digits with clamping load and chain wrap pulse
module lim_cnt_chain #(
  parameter int N_DIGITS = 4,
  parameter int W = 4,
  parameter logic [N_DIGITS*W-1:0] LIMITS = {4'd5, 4'd9, 4'd5, 4'd9}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [N_DIGITS*W-1:0] load_val,
  input  logic                  en,
  input  logic                  dir,
  output logic [N_DIGITS*W-1:0] count,
  output logic                  co,
  output logic                  load_err
);
  logic [N_DIGITS*W-1:0] nxt, ld;
  logic [W-1:0] d, l, v;
  logic up, dn, st, lerr, wrap;
  always_comb begin
    nxt = '0;
    ld = '0;
    d = '0;
    l = '0;
    v = '0;
    st = 1'b0;
    up = 1'b1;
    dn = 1'b1;
    lerr = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      d = count[k*W +: W];
      l = LIMITS[k*W +: W];
      v = load_val[k*W +: W];
      st = dir ? dn : up;
      nxt[k*W +: W] = !st ? d : dir ? (d == '0 ? l : d - 1'b1) : (d == l ? '0 : d + 1'b1);
      ld[k*W +: W] = v > l ? l : v;
      lerr = lerr | (v > l);
      up = up & (d == l);
      dn = dn & (d == '0);
    end
    wrap = dir ? dn : up;
  end
  always_ff @(posedge clk)
    if (!reset_n || clr) begin
      count <= '0;
      co <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count <= load ? ld : en ? nxt : count;
      co <= !load && en && wrap;
      load_err <= load && lerr;
    end
endmodule
